// File: rtl/dhcp_client_ctrl_if.sv
// Signal bundle between the DHCP client controller and its receive-summary and transmit paths.
interface dhcp_client_ctrl_if;
    logic        start;
    logic        tick1s;
    logic        dhcpoffer;
    logic        dhcpacknowledge;
    logic [31:0] YIAddr;
    logic [31:0] SIAddr;
    logic [31:0] ipleasetime;
    logic        txdone;
    logic        txdiscover;
    logic        txrequest;
    logic [31:0] reqipaddr;
    logic [31:0] serveripaddr;
    logic [31:0] intipaddr;
    logic        ipvalid;
    logic        fail;
    logic [2:0]  state;

    modport master (
        output start, tick1s, dhcpoffer, dhcpacknowledge, YIAddr, SIAddr, ipleasetime, txdone,
        input  txdiscover, txrequest, reqipaddr, serveripaddr, intipaddr, ipvalid, fail, state
    );

    modport slave (
        input  start, tick1s, dhcpoffer, dhcpacknowledge, YIAddr, SIAddr, ipleasetime, txdone,
        output txdiscover, txrequest, reqipaddr, serveripaddr, intipaddr, ipvalid, fail, state
    );
endinterface

// File: rtl/dhcp_client_ctrl.sv
// DHCP client sequencer: DISCOVER/OFFER/REQUEST/ACK acquisition, lease countdown, T1 renewal
// with retry timers, and a sticky FAIL state when acquisition retries are exhausted.
module dhcp_client_ctrl #(
    parameter int RETRY_SECS  = 4,
    parameter int MAX_RETRIES = 4
) (
    input  logic              clock,
    input  logic              reset,
    dhcp_client_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SENDDISC  = 3'd1,
        ST_WAITOFFER = 3'd2,
        ST_SENDREQ   = 3'd3,
        ST_WAITACK   = 3'd4,
        ST_BOUND     = 3'd5,
        ST_RENEW     = 3'd6,
        ST_FAIL      = 3'd7
    } state_t;

    localparam int TW = $clog2(RETRY_SECS + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [TW-1:0] RETRY_T = TW'(RETRY_SECS);
    localparam logic [RW-1:0] RETRY_M = RW'(MAX_RETRIES);

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [RW-1:0] retry_reg, retry_next;
    logic [31:0]   lease_reg, lease_next;
    logic [31:0]   t1_reg, t1_next;
    logic          renew_sent_reg, renew_sent_next;
    logic [31:0]   reqip_reg, reqip_next;
    logic [31:0]   servip_reg, servip_next;
    logic [31:0]   intip_reg, intip_next;
    logic          ipvalid_reg, ipvalid_next;
    logic          txdisc_reg, txdisc_next;
    logic          txreq_reg, txreq_next;
    logic          fail_reg, fail_next;

    logic [TW-1:0] timer_inc;
    logic [RW-1:0] retry_inc;
    logic [31:0]   lease_dec;
    logic [31:0]   lease_eff;
    logic          timeout;
    logic          exhausted;
    logic          lease_infinite;
    logic          do_bind;
    logic          do_expire;

    assign timer_inc      = (timer_reg == '1) ? timer_reg : timer_reg + TW'(1);
    assign retry_inc      = (retry_reg == '1) ? retry_reg : retry_reg + RW'(1);
    assign lease_dec      = (lease_reg == 32'd0) ? 32'd0 : lease_reg - 32'd1;
    assign lease_eff      = (bus.ipleasetime == 32'd0) ? 32'd1 : bus.ipleasetime;
    assign timeout        = bus.tick1s && (timer_inc >= RETRY_T);
    assign exhausted      = (retry_inc >= RETRY_M);
    assign lease_infinite = (lease_reg == 32'hFFFF_FFFF);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            timer_reg      <= '0;
            retry_reg      <= '0;
            lease_reg      <= '0;
            t1_reg         <= '0;
            renew_sent_reg <= 1'b0;
            reqip_reg      <= '0;
            servip_reg     <= '0;
            intip_reg      <= '0;
            ipvalid_reg    <= 1'b0;
            txdisc_reg     <= 1'b0;
            txreq_reg      <= 1'b0;
            fail_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            retry_reg      <= retry_next;
            lease_reg      <= lease_next;
            t1_reg         <= t1_next;
            renew_sent_reg <= renew_sent_next;
            reqip_reg      <= reqip_next;
            servip_reg     <= servip_next;
            intip_reg      <= intip_next;
            ipvalid_reg    <= ipvalid_next;
            txdisc_reg     <= txdisc_next;
            txreq_reg      <= txreq_next;
            fail_reg       <= fail_next;
        end
    end

    // Each branch honours ack/offer > txdone > tick; a lower-priority event in the same cycle is dropped.
    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        retry_next      = retry_reg;
        lease_next      = lease_reg;
        t1_next         = t1_reg;
        renew_sent_next = renew_sent_reg;
        reqip_next      = reqip_reg;
        servip_next     = servip_reg;
        intip_next      = intip_reg;
        ipvalid_next    = ipvalid_reg;
        do_bind         = 1'b0;
        do_expire       = 1'b0;

        case (state_reg)
            ST_IDLE, ST_FAIL: begin
                if (bus.start) begin
                    state_next = ST_SENDDISC;
                    retry_next = '0;
                    timer_next = '0;
                end
            end
            ST_SENDDISC: begin
                if (bus.txdone) begin
                    state_next = ST_WAITOFFER;
                    timer_next = '0;
                end
            end
            ST_WAITOFFER: begin
                if (bus.dhcpoffer) begin
                    reqip_next  = bus.YIAddr;
                    servip_next = bus.SIAddr;
                    retry_next  = '0;
                    timer_next  = '0;
                    state_next  = ST_SENDREQ;
                end else if (timeout) begin
                    retry_next = retry_inc;
                    timer_next = '0;
                    state_next = exhausted ? ST_FAIL : ST_SENDDISC;
                end else if (bus.tick1s) begin
                    timer_next = timer_inc;
                end
            end
            ST_SENDREQ: begin
                if (bus.txdone) begin
                    state_next = ST_WAITACK;
                    timer_next = '0;
                end
            end
            ST_WAITACK: begin
                if (bus.dhcpacknowledge) begin
                    do_bind = 1'b1;
                end else if (timeout) begin
                    retry_next = retry_inc;
                    timer_next = '0;
                    state_next = exhausted ? ST_FAIL : ST_SENDREQ;
                end else if (bus.tick1s) begin
                    timer_next = timer_inc;
                end
            end
            ST_BOUND: begin
                if (bus.tick1s && !lease_infinite) begin
                    lease_next = lease_dec;
                    if (lease_dec == 32'd0) begin
                        do_expire = 1'b1;
                    end else if (lease_dec <= t1_reg) begin
                        state_next      = ST_RENEW;
                        timer_next      = '0;
                        retry_next      = '0;
                        renew_sent_next = 1'b0;
                    end
                end
            end
            ST_RENEW: begin
                if (bus.dhcpacknowledge) begin
                    do_bind = 1'b1;
                end else if (bus.txdone && !renew_sent_reg) begin
                    renew_sent_next = 1'b1;
                    timer_next      = '0;
                end else if (bus.tick1s) begin
                    if (!lease_infinite) begin
                        lease_next = lease_dec;
                    end
                    if (!lease_infinite && lease_dec == 32'd0) begin
                        do_expire = 1'b1;
                    end else if (renew_sent_reg) begin
                        // Renewal never gives up: a timeout just re-arms the REQUEST.
                        if (timeout) begin
                            retry_next      = retry_inc;
                            timer_next      = '0;
                            renew_sent_next = 1'b0;
                        end else begin
                            timer_next = timer_inc;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (do_bind) begin
            intip_next      = bus.YIAddr;
            ipvalid_next    = 1'b1;
            lease_next      = lease_eff;
            t1_next         = lease_eff >> 1;
            state_next      = ST_BOUND;
            renew_sent_next = 1'b0;
            timer_next      = '0;
        end
        if (do_expire) begin
            intip_next      = '0;
            ipvalid_next    = 1'b0;
            state_next      = ST_SENDDISC;
            retry_next      = '0;
            timer_next      = '0;
            renew_sent_next = 1'b0;
        end
    end

    always_comb begin
        txdisc_next = (state_next == ST_SENDDISC);
        txreq_next  = (state_next == ST_SENDREQ) || ((state_next == ST_RENEW) && !renew_sent_next);
        fail_next   = (state_next == ST_FAIL);
    end

    assign bus.txdiscover   = txdisc_reg;
    assign bus.txrequest    = txreq_reg;
    assign bus.reqipaddr    = reqip_reg;
    assign bus.serveripaddr = servip_reg;
    assign bus.intipaddr    = intip_reg;
    assign bus.ipvalid      = ipvalid_reg;
    assign bus.fail         = fail_reg;
    assign bus.state        = state_reg;
endmodule

// File: doc/dhcp_client_ctrl.md
DHCP_CLIENT_CTRL -- requirements
Module: dhcp_client_ctrl

Interface
REQ-001 SHALL have parameter RETRY_SECS, default 4, meaning seconds to wait for an OFFER/ACK before resending.
REQ-002 SHALL have parameter MAX_RETRIES, default 4, meaning the number of consecutive unanswered sends before entering FAIL.
REQ-003 SHALL have port clock, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins address acquisition from IDLE or FAIL.
REQ-006 SHALL have port tick1s, input, 1, a one-cycle strobe once per second.
REQ-007 SHALL have ports dhcpoffer and dhcpacknowledge, input, 1 each, one-cycle pulses from the receive summary path.
REQ-008 SHALL have ports YIAddr, SIAddr and ipleasetime, input, 32 each, valid in the same cycle as the offer/ack pulse.
REQ-009 SHALL have port txdone, input, 1, a one-cycle pulse when the transmit path has sent the requested frame.
REQ-010 SHALL have port txdiscover, output, 1, a level that requests a DISCOVER frame.
REQ-011 SHALL have port txrequest, output, 1, a level that requests a REQUEST frame.
REQ-012 SHALL have ports reqipaddr and serveripaddr, output, 32 each, the offered IP and server IP used in REQUEST.
REQ-013 SHALL have port intipaddr, output, 32, the bound local IP.
REQ-014 SHALL have port ipvalid, output, 1, high while intipaddr holds a current lease.
REQ-015 SHALL have port fail, output, 1, high in the FAIL state.
REQ-016 SHALL have port state, output, 3, the state encoding: IDLE=0, SENDDISC=1, WAITOFFER=2, SENDREQ=3, WAITACK=4, BOUND=5, RENEW=6, FAIL=7.

Function
REQ-017 All logic SHALL be clocked on posedge clock; there is no asynchronous path.
REQ-018 IDLE: on start, SHALL go to SENDDISC, clear retrycnt, and clear the timer.
REQ-019 SENDDISC: txdiscover SHALL be 1; on txdone, SHALL go to WAITOFFER and clear the timer.
REQ-020 WAITOFFER: on dhcpoffer, SHALL latch reqipaddr<=YIAddr and serveripaddr<=SIAddr, go to SENDREQ, and clear retrycnt.
REQ-021 WAITOFFER: on tick1s, the timer SHALL increment; when the timer reaches RETRY_SECS, retrycnt SHALL increment and the state SHALL go to SENDDISC, or to FAIL if retrycnt+1 = MAX_RETRIES.
REQ-022 SENDREQ: txrequest SHALL be 1; on txdone, SHALL go to WAITACK and clear the timer.
REQ-023 WAITACK: on dhcpacknowledge, SHALL set intipaddr<=YIAddr and ipvalid<=1, load the lease counter<=ipleasetime and t1<=ipleasetime>>1, and go to BOUND.
REQ-024 WAITACK timeout SHALL behave as in WAITOFFER, but with the retry target SENDREQ.
REQ-025 BOUND: the lease counter SHALL decrement by 1 per tick1s; when lease <= t1, SHALL go to RENEW with the timer cleared.
REQ-026 RENEW: txrequest SHALL be 1 until txdone, then the block SHALL wait for an ack using the same timer rules, with the retry target RENEW.
REQ-027 RENEW ack: SHALL reload lease and t1 and return to BOUND; intipaddr SHALL update to YIAddr.
REQ-028 Lease expiry: when the lease counter reaches 0 in BOUND or RENEW, SHALL clear ipvalid, set intipaddr<=0, and go to SENDDISC with retrycnt cleared.
REQ-029 RENEW MAX_RETRIES exhaustion SHALL NOT enter FAIL; the block SHALL stay in RENEW and keep retrying until ack or expiry.
REQ-030 ipleasetime = 32'hFFFFFFFF SHALL mean an infinite lease: no decrement and no RENEW.
REQ-031 ipleasetime = 0 on ack SHALL be treated as a lease of 1.
REQ-032 dhcpoffer outside WAITOFFER and dhcpacknowledge outside WAITACK/RENEW SHALL be ignored.
REQ-033 Simultaneous events SHALL resolve as ack/offer > txdone > timeout/tick in the same cycle.
REQ-034 txdone outside SENDDISC, SENDREQ or RENEW-send SHALL be ignored.
REQ-035 txdiscover and txrequest SHALL never be 1 simultaneously, and each SHALL drop in the cycle after txdone.
REQ-036 FAIL: fail SHALL be 1; start SHALL re-enter SENDDISC; tick1s and rx pulses SHALL be ignored.
REQ-037 Timer and counters SHALL saturate rather than wrap.
REQ-038 Outputs SHALL be registered, with a latency of 1 cycle from the triggering input.

Reset
REQ-039 Reset SHALL force state=IDLE.
REQ-040 Reset SHALL clear txdiscover, txrequest, ipvalid and fail to 0.
REQ-041 Reset SHALL clear intipaddr, reqipaddr and serveripaddr to 0.
REQ-042 Reset SHALL clear the timer, retrycnt, lease and t1 to 0.
REQ-043 Reset asserted mid-operation, including while BOUND, SHALL drop ipvalid the next cycle, with no frame request afterwards.

Verification
REQ-044 The bench SHALL cover: start, txdone, offer YIAddr=0A000005 SIAddr=0A000001, txdone, ack lease=10 -> BOUND, intipaddr=0A000005, ipvalid=1.
REQ-045 The bench SHALL cover: bound with lease=10, 5 ticks -> RENEW with txrequest=1; ack lease=10 -> BOUND, lease=10.
REQ-046 The bench SHALL cover: start, txdone, no offer for 16 ticks (RETRY_SECS=4, MAX_RETRIES=4) -> four DISCOVER sends, then state=7, fail=1.
REQ-047 The bench SHALL cover: bound with lease=4 and no ack in RENEW -> expiry at lease 0, ipvalid=0, intipaddr=0, state=1.
REQ-048 The bench SHALL cover: offer and tick1s at timeout in the same cycle in WAITOFFER -> SENDREQ, retrycnt=0.
REQ-049 The bench SHALL cover: reset asserted while BOUND -> state=0, ipvalid=0 next cycle, and no tx request after reset is released.
